// File: rtl/npc_pkg.sv
// Shared definitions for the next-PC unit: opcodes, 2-bit counter helpers, FSM states.
// Combinational helpers only; no latency, no flow control.
package npc_pkg;

  localparam logic [5:0] OPC_REGIMM = 6'b000001;
  localparam logic [5:0] OPC_J      = 6'b000010;
  localparam logic [5:0] OPC_JAL    = 6'b000011;
  localparam logic [5:0] OPC_BEQ    = 6'b000100;
  localparam logic [5:0] OPC_BNE    = 6'b000101;
  localparam logic [5:0] OPC_BLEZ   = 6'b000110;
  localparam logic [5:0] OPC_BGTZ   = 6'b000111;

  typedef logic [1:0] ctr2_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } npc_state_t;

  function automatic ctr2_t ctr_inc(input ctr2_t c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic ctr2_t ctr_dec(input ctr2_t c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  function automatic ctr2_t ctr_next(input ctr2_t c, input logic taken);
    return taken ? ctr_inc(c) : ctr_dec(c);
  endfunction

  function automatic logic is_cond_br(input logic [5:0] opc);
    return (opc == OPC_BEQ) || (opc == OPC_BNE) || (opc == OPC_BLEZ) ||
           (opc == OPC_BGTZ) || (opc == OPC_REGIMM);
  endfunction

endpackage

// File: rtl/next_pc_unit_bht.sv
// Array of 2-bit saturating branch counters: async read of the MSB, sync update.
// Read and write at the same index in one cycle return the old counter (no bypass).
module bht_2bit
  import npc_pkg::*;
#(
  parameter int    ENTRIES  = 16,
  parameter ctr2_t CTR_INIT = 2'b01,
  parameter int    IDX_W    = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             upd,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  ctr2_t ctr [ENTRIES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_INIT;
    end else if (upd) begin
      ctr[upd_idx] <= ctr_next(ctr[upd_idx], upd_taken);
    end
  end

  assign rd_taken = ctr[rd_idx][1];

endmodule

// File: rtl/next_pc_unit.sv
// PC register with zero-cycle next-PC prediction, one-cycle-later check and 1-cycle redirect.
// Optional dynamic predictor under NEXT_PC_BHT_EN; otherwise static backward-taken prediction.
module next_pc_unit
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BHT_ENTRIES = 16,
  parameter logic [1:0]  CTR_INIT    = 2'b01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_fetch,
  input  logic        stall,
  input  logic        resolve_valid,
  input  logic        resolve_taken,
  input  logic [31:0] resolve_target,
  output logic [31:0] fetch_pc,
  output logic [31:0] next_pc,
  output logic        pred_taken,
  output logic        flush,
  output logic        halted
);

  npc_state_t  state;
  logic        d_valid;
  logic        d_pred_taken;
  logic        d_is_cond;
  logic [31:0] d_pc;
  logic [31:0] d_pred_target;

  logic [5:0]  opc;
  logic [31:0] pc4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic        f_is_cond;
  logic        f_is_jmp;
  logic        cond_taken;
  logic        f_pred_taken;
  logic [31:0] f_pred_target;
  logic        run;
  logic        mispredict;
  logic        halt_det;

  assign opc       = i_fetch[31:26];
  assign pc4       = fetch_pc + 32'd4;
  assign br_target = pc4 + {{14{i_fetch[15]}}, i_fetch[15:0], 2'b00};
  assign j_target  = {pc4[31:28], i_fetch[25:0], 2'b00};

`ifdef NEXT_PC_BHT_EN
  localparam int IDX_W = $clog2(BHT_ENTRIES);
  logic bht_upd;

  // Training follows the decode record, so it proceeds even while fetch is stalled.
  assign bht_upd = run & resolve_valid & d_valid & d_is_cond;

  bht_2bit #(
    .ENTRIES  (BHT_ENTRIES),
    .CTR_INIT (CTR_INIT),
    .IDX_W    (IDX_W)
  ) u_bht (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (fetch_pc[IDX_W+1:2]),
    .rd_taken  (cond_taken),
    .upd       (bht_upd),
    .upd_idx   (d_pc[IDX_W+1:2]),
    .upd_taken (resolve_taken)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^{CTR_INIT, BHT_ENTRIES[0], d_is_cond};
  // Backward (negative displacement) branches are assumed to be loops.
  assign cond_taken = i_fetch[15];
`endif

  assign f_is_cond     = is_cond_br(opc);
  assign f_is_jmp      = (opc == OPC_J) || (opc == OPC_JAL);
  assign f_pred_taken  = f_is_jmp | (f_is_cond & cond_taken);
  assign f_pred_target = f_is_jmp ? j_target : (f_is_cond ? br_target : pc4);

  assign run        = (state == RUN);
  assign mispredict = run & resolve_valid & d_valid &
                      ((resolve_taken != d_pred_taken) |
                       (resolve_taken & (resolve_target != d_pred_target)));
  assign halt_det   = run & (i_fetch == 32'b0) & ~stall & ~mispredict;

  always_comb begin
    next_pc = fetch_pc;
    if (mispredict)
      next_pc = resolve_taken ? resolve_target : d_pc + 32'd4;
    else if (run & ~halt_det & ~stall)
      next_pc = f_pred_taken ? f_pred_target : pc4;
  end

  assign flush      = mispredict;
  assign pred_taken = run & f_pred_taken;
  assign halted     = (state == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      fetch_pc      <= RESET_PC;
      d_valid       <= 1'b0;
      d_pred_taken  <= 1'b0;
      d_is_cond     <= 1'b0;
      d_pc          <= RESET_PC;
      d_pred_target <= RESET_PC;
    end else begin
      // next_pc already equals fetch_pc in every hold case.
      fetch_pc <= next_pc;
      if (mispredict) begin
        d_valid <= 1'b0;
      end else if (run & ~stall) begin
        if (halt_det) begin
          state   <= HALT;
          d_valid <= 1'b0;
        end else begin
          d_valid       <= 1'b1;
          d_pc          <= fetch_pc;
          d_pred_taken  <= f_pred_taken;
          d_pred_target <= f_pred_target;
          d_is_cond     <= f_is_cond;
        end
      end
    end
  end

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed, table-driven bench for next_pc_unit with RESET_PC = 0x100.
module tb_next_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_fetch;
  logic        stall;
  logic        resolve_valid;
  logic        resolve_taken;
  logic [31:0] resolve_target;
  logic [31:0] fetch_pc;
  logic [31:0] next_pc;
  logic        pred_taken;
  logic        flush;
  logic        halted;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  next_pc_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_fetch        (i_fetch),
    .stall          (stall),
    .resolve_valid  (resolve_valid),
    .resolve_taken  (resolve_taken),
    .resolve_target (resolve_target),
    .fetch_pc       (fetch_pc),
    .next_pc        (next_pc),
    .pred_taken     (pred_taken),
    .flush          (flush),
    .halted         (halted)
  );

  typedef struct {
    logic [31:0] ins;
    logic        stl;
    logic        rv;
    logic        rt;
    logic [31:0] rtg;
    logic [31:0] e_pc;
    logic [31:0] e_next;
    logic        e_pt;
    logic        e_fl;
    logic        e_h;
  } vec_t;

  localparam logic [31:0] NOP   = 32'h0000_0020;
  localparam logic [31:0] ZERO  = 32'h0000_0000;
  localparam logic [31:0] JR    = 32'h03E0_0008;
  localparam logic [31:0] BEQ   = 32'h1000_0010;  // imm +0x10
  localparam logic [31:0] BEQB  = 32'h1000_FFFC;  // imm -4
  localparam logic [31:0] J040  = 32'h0800_0040;
  localparam logic [31:0] J080  = 32'h0800_0080;
  localparam logic [31:0] J0C0  = 32'h0800_00C0;
  localparam logic [31:0] J100  = 32'h0800_0100;

  vec_t vq[$];

  function automatic vec_t mk(input logic [31:0] ins, input logic stl, input logic rv,
                              input logic rt, input logic [31:0] rtg, input logic [31:0] pc,
                              input logic [31:0] nxt, input logic pt, input logic fl,
                              input logic h);
    vec_t v;
    v.ins = ins; v.stl = stl; v.rv = rv; v.rt = rt; v.rtg = rtg;
    v.e_pc = pc; v.e_next = nxt; v.e_pt = pt; v.e_fl = fl; v.e_h = h;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h, want %h", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    i_fetch        = v.ins;
    stall          = v.stl;
    resolve_valid  = v.rv;
    resolve_taken  = v.rt;
    resolve_target = v.rtg;
    @(negedge clk);
    chk("fetch_pc",   idx, fetch_pc,   v.e_pc);
    chk("next_pc",    idx, next_pc,    v.e_next);
    chk("pred_taken", idx, pred_taken, v.e_pt);
    chk("flush",      idx, flush,      v.e_fl);
    chk("halted",     idx, halted,     v.e_h);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Sequential start-up, then a beq at 0x200 (imm +0x10 -> target 0x244).
    vq.push_back(mk(NOP,  0, 0, 0, 0,     32'h100, 32'h104, 0, 0, 0));
    vq.push_back(mk(NOP,  0, 0, 0, 0,     32'h104, 32'h108, 0, 0, 0));
    vq.push_back(mk(NOP,  0, 0, 0, 0,     32'h108, 32'h10C, 0, 0, 0));
    vq.push_back(mk(J080, 0, 0, 0, 0,     32'h10C, 32'h200, 1, 0, 0));
    vq.push_back(mk(BEQ,  0, 1, 1, 32'h200, 32'h200, 32'h204, 0, 0, 0));
    vq.push_back(mk(NOP,  0, 1, 1, 32'h244, 32'h204, 32'h244, 0, 1, 0));
    vq.push_back(mk(J080, 0, 0, 0, 0,     32'h244, 32'h200, 1, 0, 0));
`ifdef NEXT_PC_BHT_EN
    // Counter now 10: predicted taken; trains to 11, saturates, then one not-taken -> 10.
    vq.push_back(mk(BEQ,  0, 1, 1, 32'h200, 32'h200, 32'h244, 1, 0, 0));
    vq.push_back(mk(NOP,  0, 1, 1, 32'h244, 32'h244, 32'h248, 0, 0, 0));
    vq.push_back(mk(J080, 0, 0, 0, 0,     32'h248, 32'h200, 1, 0, 0));
    vq.push_back(mk(BEQ,  0, 0, 0, 0,     32'h200, 32'h244, 1, 0, 0));
    vq.push_back(mk(NOP,  0, 1, 1, 32'h244, 32'h244, 32'h248, 0, 0, 0));
    vq.push_back(mk(J080, 0, 0, 0, 0,     32'h248, 32'h200, 1, 0, 0));
    vq.push_back(mk(BEQ,  0, 0, 0, 0,     32'h200, 32'h244, 1, 0, 0));
    vq.push_back(mk(NOP,  0, 1, 0, 0,     32'h244, 32'h204, 0, 1, 0));
    vq.push_back(mk(J080, 0, 0, 0, 0,     32'h204, 32'h200, 1, 0, 0));
    vq.push_back(mk(BEQ,  0, 0, 0, 0,     32'h200, 32'h244, 1, 0, 0));
    vq.push_back(mk(J0C0, 0, 0, 0, 0,     32'h244, 32'h300, 1, 0, 0));
`else
    // Static: forward beq stays not-taken; backward beq predicted taken.
    vq.push_back(mk(BEQ,  0, 1, 1, 32'h200, 32'h200, 32'h204, 0, 0, 0));
    vq.push_back(mk(NOP,  0, 1, 1, 32'h244, 32'h204, 32'h244, 0, 1, 0));
    vq.push_back(mk(BEQB, 0, 0, 0, 0,     32'h244, 32'h238, 1, 0, 0));
    vq.push_back(mk(J0C0, 0, 1, 1, 32'h238, 32'h238, 32'h300, 1, 0, 0));
`endif
    // jr redirect, then far jump region via redirect, j within 0x1000_0000 region.
    vq.push_back(mk(JR,   0, 0, 0, 0,     32'h300, 32'h304, 0, 0, 0));
    vq.push_back(mk(NOP,  0, 1, 1, 32'h500, 32'h304, 32'h500, 0, 1, 0));
    vq.push_back(mk(NOP,  0, 0, 0, 0,     32'h500, 32'h504, 0, 0, 0));
    vq.push_back(mk(JR,   0, 0, 0, 0,     32'h504, 32'h508, 0, 0, 0));
    vq.push_back(mk(NOP,  0, 1, 1, 32'h1000_0000, 32'h508, 32'h1000_0000, 0, 1, 0));
    vq.push_back(mk(J040, 0, 0, 0, 0,     32'h1000_0000, 32'h1000_0100, 1, 0, 0));
    vq.push_back(mk(NOP,  0, 1, 1, 32'h1000_0100, 32'h1000_0100, 32'h1000_0104, 0, 0, 0));
    // Three stall cycles on a taken jump; mispredict of the older jr wins in the 2nd.
    vq.push_back(mk(JR,   0, 0, 0, 0,     32'h1000_0104, 32'h1000_0108, 0, 0, 0));
    vq.push_back(mk(J080, 1, 0, 0, 0,     32'h1000_0108, 32'h1000_0108, 1, 0, 0));
    vq.push_back(mk(J080, 1, 1, 1, 32'h600, 32'h1000_0108, 32'h600, 1, 1, 0));
    vq.push_back(mk(NOP,  1, 1, 1, 32'h999, 32'h600, 32'h600, 0, 0, 0));
    vq.push_back(mk(NOP,  0, 0, 0, 0,     32'h600, 32'h604, 0, 0, 0));
    // Wrong-path zero word is cancelled; a real zero at 0x400 halts.
    vq.push_back(mk(J100, 0, 0, 0, 0,     32'h604, 32'h400, 1, 0, 0));
    vq.push_back(mk(JR,   0, 0, 0, 0,     32'h400, 32'h404, 0, 0, 0));
    vq.push_back(mk(ZERO, 0, 1, 1, 32'h410, 32'h404, 32'h410, 0, 1, 0));
    vq.push_back(mk(J100, 0, 0, 0, 0,     32'h410, 32'h400, 1, 0, 0));
    vq.push_back(mk(ZERO, 0, 0, 0, 0,     32'h400, 32'h400, 0, 0, 0));
    vq.push_back(mk(NOP,  0, 1, 1, 32'h777, 32'h400, 32'h400, 0, 0, 1));
    vq.push_back(mk(J080, 0, 0, 0, 0,     32'h400, 32'h400, 0, 0, 1));
    vq.push_back(mk(NOP,  0, 0, 0, 0,     32'h400, 32'h400, 0, 0, 1));

    rst_n          = 1'b0;
    i_fetch        = NOP;
    stall          = 1'b1;
    resolve_valid  = 1'b0;
    resolve_taken  = 1'b0;
    resolve_target = 32'h0;
    #12;
    chk("rst_fetch_pc",   0, fetch_pc,   32'h100);
    chk("rst_halted",     0, halted,     1'b0);
    chk("rst_flush",      0, flush,      1'b0);
    chk("rst_pred_taken", 0, pred_taken, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

    // Reset out of HALT; a resolve right after reset has no record to check.
    rst_n = 1'b0;
    stall = 1'b1;
    #2;
    chk("mid_rst_fetch_pc", 0, fetch_pc, 32'h100);
    chk("mid_rst_halted",   0, halted,   1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply(mk(NOP, 0, 1, 1, 32'h888, 32'h100, 32'h104, 0, 0, 0), 1000);
    apply(mk(NOP, 0, 0, 0, 0,       32'h104, 32'h108, 0, 0, 0), 1001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
